// File: rtl/bip_pkg.sv
// ============================================================================
// Module  : bip_pkg
// Brief   : Opcodes, FSM state codes, select codes and control-word types for
//           the BIP sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bip_pkg;

    localparam int OPC_WIDTH = 5;

    localparam logic [OPC_WIDTH-1:0] OPC_HLT  = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OPC_STO  = 5'b00001;
    localparam logic [OPC_WIDTH-1:0] OPC_LD   = 5'b00010;
    localparam logic [OPC_WIDTH-1:0] OPC_LDI  = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OPC_ADD  = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OPC_ADDI = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OPC_SUB  = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OPC_SUBI = 5'b00111;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_MEM_RD = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    // Datapath controls that depend on the opcode; only driven during EXEC.
    typedef struct packed {
        logic       wr_ram;
        logic       wr_acc;
        logic [1:0] sel_a;
        logic       sel_b;
        logic       op_sub;
    } ctrl_t;

    typedef struct packed {
        logic  ir_load;
        logic  wr_pc;
        logic  rd_ram;
        logic  busy;
        logic  halted;
        ctrl_t ctrl;
    } outs_t;

endpackage

`default_nettype wire

// File: rtl/bip_decoder.sv
// ============================================================================
// Module  : bip_decoder
// Brief   : Combinational opcode decode into sequencing flags and EXEC controls.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_decoder
    import bip_pkg::*;
(
    input  logic [OPC_WIDTH-1:0] opcode,
    output logic                 needs_mem,
    output logic                 is_halt,
    output logic                 illegal,
    output ctrl_t                ctrl
);

    always_comb begin
        needs_mem = 1'b0;
        is_halt   = 1'b0;
        illegal   = 1'b0;
        ctrl      = '0;
        case (opcode)
            OPC_HLT:  is_halt = 1'b1;
            OPC_STO:  ctrl.wr_ram = 1'b1;
            OPC_LD: begin
                needs_mem   = 1'b1;
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_MEM;
            end
            OPC_LDI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_IMM;
            end
            OPC_ADD: begin
                needs_mem   = 1'b1;
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_ALU;
            end
            OPC_ADDI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = 1'b1;
            end
            OPC_SUB: begin
                needs_mem   = 1'b1;
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.op_sub = 1'b1;
            end
            OPC_SUBI: begin
                ctrl.wr_acc = 1'b1;
                ctrl.sel_a  = SEL_A_ALU;
                ctrl.sel_b  = 1'b1;
                ctrl.op_sub = 1'b1;
            end
            default:  illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/bip_sequencer.sv
// ============================================================================
// Module  : bip_sequencer
// Brief   : Multicycle FETCH/DECODE/MEM_RD/EXEC control unit for the BIP core.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bip_sequencer
    import bip_pkg::*;
#(
    parameter int OPC_W = 5,
    parameter int OPR_W = 11,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   step_mode,
    input  logic                   stop,
    input  logic [OPC_W+OPR_W-1:0] instr,
    output logic                   ir_load,
    output logic                   wr_pc,
    output logic                   rd_ram,
    output logic                   wr_ram,
    output logic                   wr_acc,
    output logic [1:0]             sel_a,
    output logic                   sel_b,
    output logic                   op_sub,
    output logic                   busy,
    output logic                   halted,
    output logic                   illegal,
    output logic [CNT_W-1:0]       instr_cnt
);

    logic [2:0]       state_q, state_d;
    logic [OPC_W-1:0] opc_q, opc_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    outs_t            outs_q, outs_d;

    logic             dec_needs_mem;
    logic             dec_is_halt;
    logic             dec_illegal;
    ctrl_t            dec_ctrl;

    // The operand field is consumed by the datapath, not here.
    logic             unused_opr;
    assign unused_opr = ^instr[OPR_W-1:0];

    bip_decoder u_decoder (
        .opcode    (opc_q),
        .needs_mem (dec_needs_mem),
        .is_halt   (dec_is_halt),
        .illegal   (dec_illegal),
        .ctrl      (dec_ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && !stop) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (dec_is_halt || dec_illegal) state_d = S_HALT;
                else if (dec_needs_mem)         state_d = S_MEM_RD;
                else                            state_d = S_EXEC;
            end
            S_MEM_RD: state_d = S_EXEC;
            S_EXEC:   state_d = (stop || step_mode) ? S_IDLE : S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered value always
    // describes the state the FSM is in during that cycle.
    always_comb begin
        opc_d     = (state_q == S_FETCH) ? instr[OPC_W+OPR_W-1 -: OPC_W] : opc_q;
        illegal_d = illegal_q | ((state_q == S_DECODE) && dec_illegal);
        cnt_d     = cnt_q;
        if ((state_q == S_EXEC) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;

        outs_d      = '0;
        outs_d.busy = (state_d != S_IDLE) && (state_d != S_HALT);
        case (state_d)
            S_FETCH:  outs_d.ir_load = 1'b1;
            S_MEM_RD: outs_d.rd_ram  = 1'b1;
            S_EXEC: begin
                outs_d.wr_pc = 1'b1;
                outs_d.ctrl  = dec_ctrl;
            end
            S_HALT:   outs_d.halted  = 1'b1;
            default:  outs_d.busy    = outs_d.busy;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            opc_q     <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            outs_q    <= '0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            outs_q    <= outs_d;
        end
    end

    assign ir_load   = outs_q.ir_load;
    assign wr_pc     = outs_q.wr_pc;
    assign rd_ram    = outs_q.rd_ram;
    assign wr_ram    = outs_q.ctrl.wr_ram;
    assign wr_acc    = outs_q.ctrl.wr_acc;
    assign sel_a     = outs_q.ctrl.sel_a;
    assign sel_b     = outs_q.ctrl.sel_b;
    assign op_sub    = outs_q.ctrl.op_sub;
    assign busy      = outs_q.busy;
    assign halted    = outs_q.halted;
    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

endmodule

`default_nettype wire
